serial_addsub: RTL and testbench

- Parametrised bit-serial adder/subtractor built around a single full-adder cell and a carry flip-flop.
- Accepts two WIDTH-bit operands through a valid/ready handshake and processes one bit per clock, LSB first.
- Presents the sum/difference, carry-out and signed overflow through a second valid/ready handshake.
- Trades latency for area; it is the next-generation arithmetic primitive in the lab datapath.

---
 rtl/arith_pkg.sv | 20 ++
 rtl/fa_cell.sv | 13 +
 rtl/serial_addsub.sv | 111 +++++++++++
 tb/tb_serial_addsub.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic primitives.
package arith_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam int MAX_WIDTH = 64;
   localparam int CNT_W_MAX = $clog2(MAX_WIDTH);

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   function automatic int cnt_w(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder; the only arithmetic in the serial datapath.
module fa_cell (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic c
);

   assign s = x ^ y ^ cin;
   assign c = (x & y) | ((x ^ y) & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell, one bit per clock,
// LSB first, with valid/ready handshakes on operands and result.
module serial_addsub
   import arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int CW = cnt_w(WIDTH);

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic             cmsb;
   logic [CW-1:0]    cnt;
   logic             fs;
   logic             fc;
   logic             accept;
   logic             pre;
   logic             last;

   fa_cell u_fa (
      .x   (opa[0]),
      .y   (opb[0]),
      .cin (carry),
      .s   (fs),
      .c   (fc)
   );

   assign accept = in_valid & in_ready;
   assign pre    = (state == RUN) && (cnt == CW'(WIDTH - 2));
   assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_nx = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opa   <= '0;
         opb   <= '0;
         acc   <= '0;
         carry <= 1'b0;
         cmsb  <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else if (accept) begin
         opa   <= a;
         opb   <= (sub == MODE_SUB) ? ~b : b;
         carry <= (sub == MODE_SUB);
         cnt   <= '0;
      end else if (state == RUN) begin
         opa   <= {1'b0, opa[WIDTH-1:1]};
         opb   <= {1'b0, opb[WIDTH-1:1]};
         acc   <= {fs, acc[WIDTH-1:1]};
         carry <= fc;
         if (!last) cnt <= cnt + 1'b1;
         if (pre)   cmsb <= fc;
         if (last) begin
            sum  <= {fs, acc[WIDTH-1:1]};
            cout <= fc;
            ovf  <= fc ^ cmsb;
         end
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and swept checks of serial_addsub at WIDTH 2, 8 and 16.
module tb_serial_addsub;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sub;
   logic        out_ready;
   logic [15:0] a;
   logic [15:0] b;

   logic       iv2, ir2, ov2, co2, of2, bz2;
   logic [1:0] s2;
   logic       iv8, ir8, ov8, co8, of8, bz8;
   logic [7:0] s8;
   logic        iv16, ir16, ov16, co16, of16, bz16;
   logic [15:0] s16;

   int checks = 0;
   int errors = 0;
   int cur_w  = 8;

   logic        sel_vld;
   logic [15:0] sel_sum;
   logic        sel_co;
   logic        sel_of;

   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(2)) u_w2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
      .a(a[1:0]), .b(b[1:0]), .sub(sub), .out_valid(ov2),
      .out_ready(out_ready), .sum(s2), .cout(co2), .ovf(of2), .busy(bz2)
   );

   serial_addsub #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
      .a(a[7:0]), .b(b[7:0]), .sub(sub), .out_valid(ov8),
      .out_ready(out_ready), .sum(s8), .cout(co8), .ovf(of8), .busy(bz8)
   );

   serial_addsub #(.WIDTH(16)) u_w16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
      .a(a), .b(b), .sub(sub), .out_valid(ov16),
      .out_ready(out_ready), .sum(s16), .cout(co16), .ovf(of16), .busy(bz16)
   );

   always_comb begin
      sel_vld = 1'b0;
      sel_sum = '0;
      sel_co  = 1'b0;
      sel_of  = 1'b0;
      case (cur_w)
         2: begin
            sel_vld = ov2; sel_sum = {14'd0, s2}; sel_co = co2; sel_of = of2;
         end
         8: begin
            sel_vld = ov8; sel_sum = {8'd0, s8}; sel_co = co8; sel_of = of8;
         end
         16: begin
            sel_vld = ov16; sel_sum = s16; sel_co = co16; sel_of = of16;
         end
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_iv(input int w, input logic v);
      case (w)
         2:  iv2  = v;
         8:  iv8  = v;
         16: iv16 = v;
         default: ;
      endcase
   endtask

   // Independent model: integer arithmetic on unsigned and signed views.
   function automatic void ref_op(input int w, input logic [15:0] x,
      input logic [15:0] y, input logic s, output logic [15:0] r,
      output logic co, output logic of);
      longint m, ux, uy, sx, sy, ur, sr, half;
      m    = (64'sd1 <<< w) - 1;
      half = 64'sd1 <<< (w - 1);
      ux   = longint'(x) & m;
      uy   = longint'(y) & m;
      sx   = (ux >= half) ? ux - (m + 1) : ux;
      sy   = (uy >= half) ? uy - (m + 1) : uy;
      ur   = s ? ux - uy : ux + uy;
      sr   = s ? sx - sy : sx + sy;
      r    = 16'(ur & m);
      co   = s ? (ux >= uy) : (ur > m);
      of   = (sr > half - 1) || (sr < -half);
   endfunction

   task automatic run_op(input int w, input logic [15:0] x,
      input logic [15:0] y, input logic s, output logic [15:0] r,
      output logic co, output logic of, output int lat);
      cur_w = w;
      @(negedge clk);
      a = x; b = y; sub = s;
      set_iv(w, 1'b1);
      @(negedge clk);
      set_iv(w, 1'b0);
      a = 16'($urandom);
      b = 16'($urandom);
      sub = 1'($urandom);
      lat = 0;
      while (!sel_vld && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      r  = sel_sum;
      co = sel_co;
      of = sel_of;
      @(negedge clk);
      chk("out_valid_one_cycle", sel_vld, 0);
   endtask

   task automatic dir8(input string tag, input logic [7:0] x,
      input logic [7:0] y, input logic s, input logic [7:0] es,
      input logic ec, input logic eo);
      logic [15:0] r;
      logic        co, of;
      int          lat;
      run_op(8, {8'd0, x}, {8'd0, y}, s, r, co, of, lat);
      chk({tag, "_lat"},  lat, 8);
      chk({tag, "_sum"},  r,   {8'd0, es});
      chk({tag, "_cout"}, co,  ec);
      chk({tag, "_ovf"},  of,  eo);
   endtask

   task automatic sweep(input int w, input logic [15:0] x,
      input logic [15:0] y, input logic s);
      logic [15:0] r, er;
      logic        co, of, eco, eof;
      int          lat;
      run_op(w, x, y, s, r, co, of, lat);
      ref_op(w, x, y, s, er, eco, eof);
      chk("sweep_lat", lat, w);
      chk("sweep_sum", r, er);
      chk("sweep_cout", co, eco);
      chk("sweep_ovf", of, eof);
   endtask

   initial begin
      logic [7:0] held;
      int         acc_n, bad, last_acc, gap, n;

      rst_n = 1'b0; out_ready = 1'b1; sub = 1'b0;
      a = '0; b = '0; iv2 = 0; iv8 = 0; iv16 = 0;
      #2;
      chk("rst_sum", s8, 0);
      chk("rst_flags", {co8, of8, ov8, bz8}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", ir8, 1);

      dir8("add_basic", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
      dir8("add_carry", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      dir8("add_ovf",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      dir8("sub_borrow", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
      dir8("sub_ovf",   8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

      // Result held while the consumer stalls.
      cur_w = 8;
      out_ready = 1'b0;
      @(negedge clk);
      a = 16'h21; b = 16'h10; sub = 1'b0; iv8 = 1'b1;
      @(negedge clk);
      iv8 = 1'b0;
      n = 0;
      while (!ov8 && n < 64) begin
         @(negedge clk);
         n++;
      end
      chk("stall_lat", n, 8);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_valid", ov8, 1);
         chk("stall_sum", s8, 8'h31);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("stall_release", {ov8, bz8}, 0);
      chk("stall_keep_sum", s8, 8'h31);

      // in_valid held high: one accept every WIDTH+2 cycles.
      a = 16'h12; b = 16'h34; sub = 1'b0;
      @(negedge clk);
      iv8 = 1'b1;
      acc_n = 0; bad = 0; last_acc = -1; gap = 0;
      for (int i = 0; i < 30; i++) begin
         if (iv8 && ir8) begin
            if (last_acc >= 0) gap = i - last_acc;
            last_acc = i;
            acc_n++;
         end
         if (bz8 && ir8) bad++;
         @(negedge clk);
      end
      iv8 = 1'b0;
      chk("held_accepts", acc_n, 3);
      chk("held_gap", gap, 10);
      chk("held_ready_busy", bad, 0);
      n = 0;
      while (bz8 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("held_drain", bz8, 0);
      chk("held_sum", s8, 8'h46);

      // Reset in the middle of RUN.
      @(negedge clk);
      a = 16'hFF; b = 16'h01; sub = 1'b0; iv8 = 1'b1;
      @(negedge clk);
      iv8 = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_busy", bz8, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_sum", s8, 0);
      chk("mid_rst_flags", {co8, of8, ov8, bz8}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_in_ready", ir8, 1);
      chk("mid_no_valid", ov8, 0);
      dir8("post_rst", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);

      for (int x = 0; x < 4; x++)
         for (int y = 0; y < 4; y++)
            for (int s = 0; s < 2; s++)
               sweep(2, 16'(x), 16'(y), 1'(s));

      for (int i = 0; i < 1000; i++)
         sweep(16, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
